mux_n_way_reg: RTL and testbench

MUX_N_WAY_REG -- requirements
Module: mux_n_way_reg

---
 rtl/mux_n_way_reg.sv | 143 ++++++++++++++
 tb/tb_mux_n_way_reg.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mux_n_way_reg.sv
// Registered N-way channel multiplexer with a one-word output stage; fixed-select mode always,
// round-robin selection compiled in only when MUX_N_WAY_RR_EN is defined.
module mux_n_way_reg #(
  parameter int unsigned WIDTH    = 5,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          select,
  input  logic                      mode,
  output logic [WIDTH-1:0]          out,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int unsigned IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             load;
  logic             chosen;
  logic             xfer;
  logic             fixed_hit;
  logic [IDX_W-1:0] fixed_chan;
  logic [IDX_W-1:0] chan;
  logic [WIDTH-1:0] ch_data [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*WIDTH +: WIDTH];
  end

  // Out-of-range select chooses nothing; index is parked at 0 so it never leaves the array.
  always_comb begin : fixed_pick
    fixed_hit  = (32'(select) < CHANNELS);
    fixed_chan = '0;
    if (fixed_hit) begin
      fixed_chan = IDX_W'(select);
    end
  end

`ifdef MUX_N_WAY_RR_EN
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] rr_chan;
  logic             rr_hit;
  logic [IDX_W-1:0] chan_next;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned     ofs);
    int unsigned sum;
    sum = 32'(base) + ofs;
    if (sum >= CHANNELS) begin
      sum = sum - CHANNELS;
    end
    return IDX_W'(sum);
  endfunction

  // First valid channel at or after rr_ptr, wrapping past the last channel.
  always_comb begin : rr_scan
    rr_chan = '0;
    rr_hit  = 1'b0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (!rr_hit && in_valid[wrap_idx(rr_ptr, k)]) begin
        rr_hit  = 1'b1;
        rr_chan = wrap_idx(rr_ptr, k);
      end
    end
  end

  always_comb begin : pick
    chan   = fixed_chan;
    chosen = fixed_hit;
    if (mode) begin
      chan   = rr_chan;
      chosen = rr_hit;
    end
  end

  assign chan_next = (chan == LAST_IDX) ? '0 : chan + IDX_W'(1);

  always_ff @(posedge clk) begin : rr_reg
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= chan_next;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;

  always_comb begin : pick
    chan   = fixed_chan;
    chosen = fixed_hit;
  end
`endif

  // The output register may take a new word when empty or when its word is being taken.
  assign load = ((state_q == EMPTY) || out_ready) && !rst;
  assign xfer = load && chosen && in_valid[chan];

  always_ff @(posedge clk) begin : state_reg
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    if (load) begin
      state_d = xfer ? FULL : EMPTY;
    end
  end

  always_comb begin : outputs
    in_ready  = '0;
    out_valid = (state_q == FULL);
    if (load && chosen) begin
      in_ready[chan] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin : data_reg
    if (rst) begin
      out <= '0;
    end else if (xfer) begin
      out <= ch_data[chan];
    end
  end

endmodule

// File: tb/tb_mux_n_way_reg.sv
// Scoreboard bench for mux_n_way_reg: directed vectors push expected words, a monitor pops them
// on every out_valid&&out_ready beat. Round-robin vectors run when MUX_N_WAY_RR_EN is defined.
module tb_mux_n_way_reg;
  localparam int unsigned WIDTH    = 5;
  localparam int unsigned CHANNELS = 4;
  localparam int unsigned SEL_W    = 3;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [SEL_W-1:0]          select;
  logic                      mode;
  logic [WIDTH-1:0]          out;
  logic                      out_valid;
  logic                      out_ready;

  logic [WIDTH-1:0] d [CHANNELS];
  logic [WIDTH-1:0] exp_q [$];
  int               vectors     = 0;
  int               miscompares = 0;

  always #5 clk = ~clk;
  assign in_data = {d[3], d[2], d[1], d[0]};

  mux_n_way_reg #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .select(select), .mode(mode), .out(out), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a beat is out_valid&&out_ready as it will be seen at the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL beat: got %0h, expected no beat", out);
      end else begin
        check("beat", 32'(out), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic apply(input string name, input logic r, input logic [3:0] iv,
                       input logic [2:0] sel, input logic md, input logic ordy,
                       input logic [3:0] exp_rdy);
    rst       = r;
    in_valid  = iv;
    select    = sel;
    mode      = md;
    out_ready = ordy;
    #1;
    check({name, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string name, input logic ov, input logic [4:0] o);
    check({name, ".out_valid"}, 32'(out_valid), 32'(ov));
    check({name, ".out"}, 32'(out), 32'(o));
  endtask

  initial begin
    d[0] = 5'h01; d[1] = 5'h0A; d[2] = 5'h15; d[3] = 5'h1F;

    // Reset with every channel valid: nothing accepted, output cleared.
    apply("rst", 1'b1, 4'b1111, 3'd0, 1'b0, 1'b1, 4'b0000);
    expect_out("rst", 1'b0, 5'h00);
    // First edge after release behaves as EMPTY and loads ch0.
    exp_q.push_back(5'h01);
    apply("release", 1'b0, 4'b1111, 3'd0, 1'b0, 1'b1, 4'b0001);
    expect_out("release", 1'b1, 5'h01);

    exp_q.push_back(5'h15);
    apply("fixed2", 1'b0, 4'b0100, 3'd2, 1'b0, 1'b1, 4'b0100);
    expect_out("fixed2", 1'b1, 5'h15);

    exp_q.push_back(5'h0A);
    apply("fixed1", 1'b0, 4'b0010, 3'd1, 1'b0, 1'b1, 4'b0010);
    expect_out("fixed1", 1'b1, 5'h0A);

    // Backpressure: held word must survive input churn.
    d[1] = 5'h11;
    apply("hold1", 1'b0, 4'b1111, 3'd1, 1'b0, 1'b0, 4'b0000);
    expect_out("hold1", 1'b1, 5'h0A);
    d[0] = 5'h07;
    apply("hold2", 1'b0, 4'b0101, 3'd0, 1'b0, 1'b0, 4'b0000);
    expect_out("hold2", 1'b1, 5'h0A);
    apply("hold3", 1'b0, 4'b1111, 3'd3, 1'b1, 1'b0, 4'b0000);
    expect_out("hold3", 1'b1, 5'h0A);

    exp_q.push_back(5'h1F);
    apply("release_bp", 1'b0, 4'b1000, 3'd3, 1'b0, 1'b1, 4'b1000);
    expect_out("release_bp", 1'b1, 5'h1F);

    // Out-of-range select: nothing chosen, output drains.
    apply("sel5", 1'b0, 4'b1111, 3'd5, 1'b0, 1'b1, 4'b0000);
    expect_out("sel5", 1'b0, 5'h1F);

`ifdef MUX_N_WAY_RR_EN
    d[0] = 5'h01; d[1] = 5'h02; d[2] = 5'h03; d[3] = 5'h04;
    exp_q.push_back(5'h01);
    apply("rr0", 1'b0, 4'b1111, 3'd3, 1'b1, 1'b1, 4'b0001);
    expect_out("rr0", 1'b1, 5'h01);
    exp_q.push_back(5'h02);
    apply("rr1", 1'b0, 4'b1111, 3'd3, 1'b1, 1'b1, 4'b0010);
    expect_out("rr1", 1'b1, 5'h02);
    exp_q.push_back(5'h03);
    apply("rr2", 1'b0, 4'b1111, 3'd3, 1'b1, 1'b1, 4'b0100);
    expect_out("rr2", 1'b1, 5'h03);
    exp_q.push_back(5'h04);
    apply("rr3", 1'b0, 4'b1111, 3'd3, 1'b1, 1'b1, 4'b1000);
    expect_out("rr3", 1'b1, 5'h04);
    exp_q.push_back(5'h01);
    apply("rr_wrap", 1'b0, 4'b1111, 3'd3, 1'b1, 1'b1, 4'b0001);
    expect_out("rr_wrap", 1'b1, 5'h01);
    exp_q.push_back(5'h02);
    apply("rr_ch1a", 1'b0, 4'b0010, 3'd3, 1'b1, 1'b1, 4'b0010);
    expect_out("rr_ch1a", 1'b1, 5'h02);
    exp_q.push_back(5'h02);
    apply("rr_ch1b", 1'b0, 4'b0010, 3'd3, 1'b1, 1'b1, 4'b0010);
    expect_out("rr_ch1b", 1'b1, 5'h02);
`else
    // Without round-robin, mode is ignored and select alone decides.
    d[3] = 5'h13;
    exp_q.push_back(5'h13);
    apply("mode_ignored", 1'b0, 4'b1111, 3'd3, 1'b1, 1'b1, 4'b1000);
    expect_out("mode_ignored", 1'b1, 5'h13);
`endif

    // Back-to-back throughput on ch0.
    d[0] = 5'h04;
    exp_q.push_back(5'h04);
    apply("tput0", 1'b0, 4'b0001, 3'd0, 1'b0, 1'b1, 4'b0001);
    expect_out("tput0", 1'b1, 5'h04);
    d[0] = 5'h08;
    exp_q.push_back(5'h08);
    apply("tput1", 1'b0, 4'b0001, 3'd0, 1'b0, 1'b1, 4'b0001);
    expect_out("tput1", 1'b1, 5'h08);
    d[0] = 5'h10;
    exp_q.push_back(5'h10);
    apply("tput2", 1'b0, 4'b0001, 3'd0, 1'b0, 1'b1, 4'b0001);
    expect_out("tput2", 1'b1, 5'h10);

    // Chosen channel not valid: ready still offered, output drains, value held.
    apply("idle", 1'b0, 4'b0000, 3'd0, 1'b0, 1'b1, 4'b0001);
    expect_out("idle", 1'b0, 5'h10);

    // EMPTY loads even with out_ready low.
    d[2] = 5'h0C;
    exp_q.push_back(5'h0C);
    apply("empty_load", 1'b0, 4'b0100, 3'd2, 1'b0, 1'b0, 4'b0100);
    expect_out("empty_load", 1'b1, 5'h0C);
    apply("full_stall", 1'b0, 4'b0100, 3'd2, 1'b0, 1'b0, 4'b0000);
    expect_out("full_stall", 1'b1, 5'h0C);

    // Reset while FULL discards the pending word.
    void'(exp_q.pop_back());
    apply("rst_full", 1'b1, 4'b1111, 3'd2, 1'b0, 1'b0, 4'b0000);
    expect_out("rst_full", 1'b0, 5'h00);
    apply("post_rst", 1'b0, 4'b0000, 3'd1, 1'b0, 1'b1, 4'b0010);
    expect_out("post_rst", 1'b0, 5'h00);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
